systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Sequencer for an N x N grid of PE_UNIT cells (weight-free systolic matrix multiply, C = A x B).
- Latches operand matrices on start and clears the PE accumulators.
- Drives diagonally skewed, zero-padded operand wavefronts into the grid's left and top edges.
- Waits for the pipeline to drain, captures all PE results and pulses done.

Parameters:
- DATA_WIDTH, 32, operand element width; matches PE_UNIT.
- N, 4, array dimension; legal range 2..16.
- RES_WIDTH, 64, per-PE result width; matches PE_UNIT res_o.
- PE_LAT, 1, extra drain cycles after the last feed step; minimum 0.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start request; accepted only in IDLE.
- a_i  in  N*N*DATA_WIDTH  matrix A; A[r][c] at [(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
- b_i  in  N*N*DATA_WIDTH  matrix B; same layout.
- res_arr_i  in  N*N*RES_WIDTH  PE results; PE(i,j) at [(i*N+j)*RES_WIDTH +: RES_WIDTH].
- busy_o  out  1  high in every state except IDLE.
- pe_clr_o  out  1  accumulator clear to the grid, active-high; the integration inverts it to rst_ni.
- left_o  out  N*DATA_WIDTH  row-i left-edge operand at [i*DATA_WIDTH +: DATA_WIDTH].
- up_o  out  N*DATA_WIDTH  column-j top-edge operand, same layout.
- res_o  out  N*N*RES_WIDTH  captured result matrix; same layout as res_arr_i.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset values: busy_o=0, pe_clr_o=0, left_o=0, up_o=0, res_o=0, done_o=0, state=IDLE, step counter=0, operand regs=0.
- Reset asserted mid-job aborts immediately. The next cycle is IDLE with all outputs at reset values. No done_o is issued.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: start_i=1 latches a_i and b_i into internal regs and moves to CLEAR. a_i and b_i are don't-care afterwards.
- CLEAR (1 cycle): pe_clr_o=1, edges are 0. Next state is FEED with step t=0.
- FEED (3N-2 cycles, t = 0 .. 3N-3), pe_clr_o=0:
  - left_o row i = A[i][t-i] if 0 <= t-i < N, else 0.
  - up_o column j = B[t-j][j] if 0 <= t-j < N, else 0.
  - At t=3N-3 the next state is DRAIN.
- DRAIN (PE_LAT cycles; skipped if PE_LAT=0): edges are 0. Then go to DONE.
- Entering DONE: res_o <= res_arr_i.
- DONE (1 cycle): done_o=1. Next state is IDLE. res_o holds until the next job's DONE or reset.
- Timing: with start accepted at edge E0, done_o is high in cycle 3N+PE_LAT after E0 (N=2, PE_LAT=1 gives cycle 7). busy_o is high from cycle 1 through the DONE cycle.
- start_i is ignored while busy (including the DONE cycle). There is no queuing.
- start_i held high continuously: the next job begins on the first IDLE cycle after DONE.
- Step counter is $clog2(3N) bits and cannot wrap within a job.
- No arithmetic is performed in this block; result widths pass through unchanged.

Optional Feature:
- Macro: SYSTOLIC_CTRL_PERF_EN.
- Defined: adds output perf_cycles_o, 32 bits.
  - Counts cycles with busy_o=1 for the current job.
  - Saturates at all-ones.
  - Cleared when start is accepted.
  - Holds after DONE.
  - Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package systolic_pkg holds:
  - the FSM state enum (IDLE, CLEAR, FEED, DRAIN, DONE, 3-bit encoding);
  - localparam FEED_STEPS = 3N-2;
  - index helper functions for flattened A/B/result layouts, also used by the grid top and benches.
- One natural sub-module: systolic_skew_mux.
  - Combinational selection of row/column elements for step t, including zero padding.
  - Instantiated once for the left edge and once for the top edge.
  - Its outputs are registered in systolic_ctrl.

Test Plan:
- Basic multiply: N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse.
  - -> left_o row0 1,2,0,0 and row1 0,3,4,0.
  - -> up_o col0 5,7,0,0 and col1 0,6,8,0.
  - -> with the PE grid, done_o in cycle 7 and res_o=[[19,22],[43,50]].
- Clear sequencing: run the job twice back to back with the same operands.
  - -> pe_clr_o high exactly one cycle before each FEED.
  - -> second res_o equals the first (no accumulation carry-over).
- Start while busy: pulse start_i at cycles 3 and 7 of a job.
  - -> both pulses ignored, a single done_o.
  - -> start in cycle 8 (IDLE) accepted.
- Reset mid-FEED: assert rst_i at cycle 4 for one cycle.
  - -> next cycle busy_o=0, edges 0, res_o=0.
  - -> no done_o.
- Operand latching: change a_i and b_i to all 0xFFFFFFFF one cycle after start.
  - -> result still [[19,22],[43,50]].
- N=4, PE_LAT=3, A=identity, B[r][c]=r*4+c.
  - -> done_o in cycle 15, res_o equals B.
  - -> with SYSTOLIC_CTRL_PERF_EN defined, perf_cycles_o=15.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and index helpers for the systolic sequencer, the PE grid top and benches.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int N_DEFAULT  = 4;
  localparam int FEED_STEPS = 3 * N_DEFAULT - 2;

  // Feed length for an arbitrary array size; FEED_STEPS is this at the default size.
  function automatic int feed_steps(input int n);
    return 3 * n - 2;
  endfunction

  // Element index into a flattened row-major N x N matrix (A, B or results).
  function automatic int mat_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/systolic_skew_mux.sv
// Picks the operand each grid lane sees at feed step t, zero outside the skewed diagonal.
module systolic_skew_mux
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int STEP_W     = 4,
  parameter bit COL_MODE   = 1'b0
) (
  input  logic [N*N*DATA_WIDTH-1:0] mat,
  input  logic [STEP_W-1:0]         step,
  output logic [N*DATA_WIDTH-1:0]   lane
);

  // Row mode: lane i gets M[i][t-i]. Column mode: lane j gets M[t-j][j].
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    lane = '0;
    for (int k = 0; k < N; k++) begin
      int d;
      d = int'(step) - k;
      if (d >= 0 && d < N) begin
        if (COL_MODE)
          lane[k*DATA_WIDTH +: DATA_WIDTH] = mat[mat_idx(d, k, N)*DATA_WIDTH +: DATA_WIDTH];
        else
          lane[k*DATA_WIDTH +: DATA_WIDTH] = mat[mat_idx(k, d, N)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic grid: clear, skewed feed, drain, capture.
// Optional busy-cycle counter on perf_cycles_o when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int RES_WIDTH  = 64,
  parameter int PE_LAT     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [N*N*DATA_WIDTH-1:0]  a_i,
  input  logic [N*N*DATA_WIDTH-1:0]  b_i,
  input  logic [N*N*RES_WIDTH-1:0]   res_arr_i,
  output logic                       busy_o,
  output logic                       pe_clr_o,
  output logic [N*DATA_WIDTH-1:0]    left_o,
  output logic [N*DATA_WIDTH-1:0]    up_o,
  output logic [N*N*RES_WIDTH-1:0]   res_o,
  output logic                       done_o
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_cycles_o
`endif
);

  localparam int STEP_W  = $clog2(3 * N);
  localparam int DRAIN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [STEP_W-1:0]  FEED_LAST  = STEP_W'(feed_steps(N) - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_LAT - 1);

  state_t                    state_q, state_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic [N*N*DATA_WIDTH-1:0] a_q, b_q;
  logic [N*DATA_WIDTH-1:0]   left_sel, up_sel;
  logic [N*DATA_WIDTH-1:0]   left_d, up_d;
  logic                      busy_d, clr_d, done_d;
  logic                      start_ok;

  assign start_ok = (state_q == IDLE) && start_i;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is only ever written with non-blocking assignments.
    if (rst_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        step_d = '0;
        if (start_i) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = FEED;
        step_d  = '0;
      end
      FEED: begin
        if (step_q == FEED_LAST) begin
          state_d = (PE_LAT == 0) ? DONE : DRAIN;
          drain_d = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Muxes look at the upcoming step so the registered edges line up with the state.
  systolic_skew_mux #(.DATA_WIDTH(DATA_WIDTH), .N(N), .STEP_W(STEP_W), .COL_MODE(1'b0)) u_left_mux (
    .mat  (a_q),
    .step (step_d),
    .lane (left_sel)
  );

  systolic_skew_mux #(.DATA_WIDTH(DATA_WIDTH), .N(N), .STEP_W(STEP_W), .COL_MODE(1'b1)) u_up_mux (
    .mat  (b_q),
    .step (step_d),
    .lane (up_sel)
  );

  always_comb begin
    busy_d = (state_d != IDLE);
    clr_d  = (state_d == CLEAR);
    done_d = (state_d == DONE);
    left_d = (state_d == FEED) ? left_sel : '0;
    up_d   = (state_d == FEED) ? up_sel   : '0;
  end

  // NOTE: the result bank is reset too, because its reset value is visible on res_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o   <= 1'b0;
      pe_clr_o <= 1'b0;
      done_o   <= 1'b0;
      left_o   <= '0;
      up_o     <= '0;
      res_o    <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      busy_o   <= busy_d;
      pe_clr_o <= clr_d;
      done_o   <= done_d;
      left_o   <= left_d;
      up_o     <= up_d;
      if (state_d == DONE) res_o <= res_arr_i;
      if (start_ok) begin
        a_q <= a_i;
        b_q <= b_i;
      end
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                        perf_cycles_o <= '0;
    else if (start_ok)                perf_cycles_o <= '0;
    else if (busy_o && !(&perf_cycles_o)) perf_cycles_o <= perf_cycles_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl driving a behavioural PE grid, checked against a job-level model.
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int N      = 4;
  localparam int DW     = 32;
  localparam int RW     = 64;
  localparam int PE_LAT = 3;
  localparam int TOTAL  = 3 * N + PE_LAT;
  localparam int NCYC   = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_i, start_i;
  logic [N*N*DW-1:0]   a_i, b_i;
  logic [N*N*RW-1:0]   res_arr, res_o;
  logic                busy, pe_clr, done;
  logic [N*DW-1:0]     left, up;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]         perf;
`endif

  systolic_ctrl #(.DATA_WIDTH(DW), .N(N), .RES_WIDTH(RW), .PE_LAT(PE_LAT)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .res_arr_i (res_arr),
    .busy_o    (busy),
    .pe_clr_o  (pe_clr),
    .left_o    (left),
    .up_o      (up),
    .res_o     (res_o),
    .done_o    (done)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_cycles_o (perf)
`endif
  );

  // Behavioural output-stationary PE grid: operands ripple right/down, products accumulate.
  logic [DW-1:0] a_pipe [N][N];
  logic [DW-1:0] b_pipe [N][N];
  logic [RW-1:0] acc    [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] ai, bi;
        ai = (j == 0) ? left[i*DW +: DW] : a_pipe[i][j-1];
        bi = (i == 0) ? up[j*DW +: DW]   : b_pipe[i-1][j];
        if (pe_clr || rst_i) begin
          acc[i][j]    <= '0;
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end else begin
          acc[i][j]    <= acc[i][j] + 64'(ai) * 64'(bi);
          a_pipe[i][j] <= ai;
          b_pipe[i][j] <= bi;
        end
      end
    end
  end

  always_comb begin
    res_arr = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        res_arr[mat_idx(i, j, N)*RW +: RW] = acc[i][j];
  end

  // Reference model: phase = cycles since the accepted start (0 = idle).
  int            phase;
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [RW-1:0] re [N][N];
  logic [31:0]   perf_exp;
  int            dones_exp, dones_seen;
  int            n_vec, n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_left(input int k, input int i);
    int d;
    if (k < 2 || k > 3 * N - 1) return '0;
    d = (k - 2) - i;
    return (d >= 0 && d < N) ? ma[i][d] : '0;
  endfunction

  function automatic logic [DW-1:0] exp_up(input int k, input int j);
    int d;
    if (k < 2 || k > 3 * N - 1) return '0;
    d = (k - 2) - j;
    return (d >= 0 && d < N) ? mb[d][j] : '0;
  endfunction

  function automatic logic [N*N*DW-1:0] rand_mat();
    logic [N*N*DW-1:0] v;
    int mode;
    mode = $urandom_range(0, 2);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[mat_idx(r, c, N)*DW +: DW] = (mode == 0) ? 32'($urandom_range(0, 15)) :
                                       (mode == 1) ? 32'($urandom) : 32'hFFFF_FFFF;
    return v;
  endfunction

  task automatic model_step();
    if (rst_i) begin
      phase    = 0;
      perf_exp = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) re[i][j] = '0;
      return;
    end
    if (phase >= 1 && perf_exp != 32'hFFFF_FFFF) perf_exp++;
    if (phase == 0) begin
      if (start_i) begin
        phase    = 1;
        perf_exp = '0;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            ma[r][c] = a_i[mat_idx(r, c, N)*DW +: DW];
            mb[r][c] = b_i[mat_idx(r, c, N)*DW +: DW];
          end
      end
    end else if (phase == TOTAL) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == TOTAL) begin
        dones_exp++;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            logic [RW-1:0] s;
            s = '0;
            for (int k = 0; k < N; k++) s += 64'(ma[i][k]) * 64'(mb[k][j]);
            re[i][j] = s;
          end
      end
    end
  endtask

  task automatic check_outputs();
    check("busy", 64'(busy), 64'(phase != 0));
    check("pe_clr", 64'(pe_clr), 64'(phase == 1));
    check("done", 64'(done), 64'(phase == TOTAL));
    for (int i = 0; i < N; i++) begin
      check($sformatf("left[%0d]@%0d", i, phase), 64'(left[i*DW +: DW]), 64'(exp_left(phase, i)));
      check($sformatf("up[%0d]@%0d", i, phase), 64'(up[i*DW +: DW]), 64'(exp_up(phase, i)));
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("res[%0d][%0d]", i, j), res_o[mat_idx(i, j, N)*RW +: RW], re[i][j]);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("perf", 64'(perf), 64'(perf_exp));
`endif
    if (done === 1'b1) dones_seen++;
  endtask

  initial begin
    bit did_feed_rst;
    n_vec = 0; n_err = 0; dones_exp = 0; dones_seen = 0;
    phase = 0; perf_exp = '0; did_feed_rst = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        re[i][j] = '0; ma[i][j] = '0; mb[i][j] = '0;
      end
    rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc >= 1) check_outputs();
      if (cyc < 2) begin
        rst_i = 1'b1; start_i = 1'b0;
      end else if (cyc == 2) begin
        // First job: identity times B[r][c] = r*N+c, result must equal B.
        rst_i = 1'b0; start_i = 1'b1;
        a_i = '0; b_i = '0;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            a_i[mat_idx(r, c, N)*DW +: DW] = (r == c) ? 32'd1 : 32'd0;
            b_i[mat_idx(r, c, N)*DW +: DW] = 32'(r * N + c);
          end
      end else begin
        // Operands are scrambled every cycle; only the value at the accepted start counts.
        a_i = rand_mat();
        b_i = rand_mat();
        start_i = (cyc >= 300 && cyc < 360) ? 1'b1 : ($urandom_range(0, 3) == 0);
        rst_i   = (cyc > 40) && ($urandom_range(0, 199) == 0);
        if (!did_feed_rst && cyc > 60 && phase == 4) begin
          rst_i = 1'b1;
          did_feed_rst = 1'b1;
        end
      end
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    check_outputs();
    check("done_count", 64'(dones_seen), 64'(dones_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
